// File: rtl/universal_register_n_if.sv
// Control/data bundle for universal_register_n: the master drives operations,
// the slave (the register) returns value, flags and sequencer handshake.
interface universal_register_n_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
);
  logic               cl, ld, inc, dec, sr, ir, sl, il, start, dir;
  logic [WIDTH-1:0]   in;
  logic [1:0]         mode;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   out;
  logic               co, zero, busy, done;

  modport master (
    output cl, ld, in, inc, dec, sr, ir, sl, il, mode, start, shamt, dir,
    input  out, co, zero, busy, done
  );
  modport slave (
    input  cl, ld, in, inc, dec, sr, ir, sl, il, mode, start, shamt, dir,
    output out, co, zero, busy, done
  );
endinterface

// File: rtl/universal_register_n.sv
// General-purpose datapath register: clear/load/inc/dec/shift/rotate with carry
// flag, plus a multi-cycle shift-by-N sequencer with busy/done handshake.
module universal_register_n #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4,
  parameter int SAT     = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  universal_register_n_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam logic [1:0] M_ROT = 2'b01;
  localparam logic [1:0] M_ARI = 2'b10;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               co_q, co_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               dir_q, dir_d;
  logic [1:0]         mode_q, mode_d;

  // Returns {shifted-out bit, new value}; mode 11 falls through to LOG.
  function automatic logic [WIDTH:0] shift1(input logic left, input logic [1:0] m,
                                            input logic [WIDTH-1:0] v,
                                            input logic si_r, input logic si_l);
    logic fill;
    if (!left) begin
      case (m)
        M_ROT:   fill = v[0];
        M_ARI:   fill = v[WIDTH-1];
        default: fill = si_r;
      endcase
      return {v[0], fill, v[WIDTH-1:1]};
    end else begin
      fill = (m == M_ROT) ? v[WIDTH-1] : si_l;
      return {v[WIDTH-1], v[WIDTH-2:0], fill};
    end
  endfunction

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    co_d    = co_q;
    count_d = count_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cl) begin
          out_d = '0;
          co_d  = 1'b0;
        end else if (bus.ld) begin
          out_d = bus.in;
          co_d  = 1'b0;
        end else if (bus.start) begin
          if (bus.shamt != '0) begin
            state_d = SHIFT;
            count_d = bus.shamt;
            dir_d   = bus.dir;
            mode_d  = bus.mode;
          end else begin
            done_d = 1'b1;
          end
        end else if (bus.inc) begin
          co_d  = &out_q;
          out_d = (&out_q && SAT != 0) ? out_q : out_q + 1'b1;
        end else if (bus.dec) begin
          co_d  = (out_q == '0);
          out_d = (out_q == '0 && SAT != 0) ? out_q : out_q - 1'b1;
        end else if (bus.sr) begin
          {co_d, out_d} = shift1(1'b0, bus.mode, out_q, bus.ir, bus.il);
        end else if (bus.sl) begin
          {co_d, out_d} = shift1(1'b1, bus.mode, out_q, bus.ir, bus.il);
        end
      end
      SHIFT: begin
        if (bus.cl) begin
          // abort: no completion pulse
          out_d   = '0;
          co_d    = 1'b0;
          count_d = '0;
          state_d = IDLE;
        end else begin
          {co_d, out_d} = shift1(dir_q, mode_q, out_q, bus.ir, bus.il);
          count_d = count_q - 1'b1;
          if (count_q == SHAMT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.co   = co_q;
  assign bus.zero = (out_q == '0);
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
